mips_debug_ctrl: RTL
====================

Name: mips_debug_ctrl

Overview:
- UART-byte-level debug controller between the UART rx/tx byte engines and the MIPS core.
- Loads instruction memory, runs, single-steps, soft-resets the core and dumps PC plus register file over the serial link.
- Parametrised in data width, register count and program depth, replacing the fixed stall tie-off at the top level.

Parameters:
- SIZE, 32, core data/instruction width in bits; must be a multiple of 8.
- NUM_REGISTERS, 32, registers dumped by 'D'.
- MAX_INSTRUCTION, 64, instruction memory depth in words.
- ADDR_WIDTH, $clog2(MAX_INSTRUCTION), instruction memory address width.
- CPU_RST_CYCLES, 4, length of the soft-reset pulse issued by 'X'.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout; used only with the optional feature.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-low reset.
- i_rx_data  in  8  received byte.
- i_rx_valid  in  1  one-cycle tick: i_rx_data is valid.
- o_tx_data  out  8  byte to transmit.
- o_tx_start  out  1  one-cycle request to transmit o_tx_data.
- i_tx_done  in  1  one-cycle tick: transmitter finished the byte.
- o_imem_wr_en  out  1  instruction memory write strobe.
- o_imem_addr  out  ADDR_WIDTH  instruction memory write address.
- o_imem_wr_data  out  SIZE  instruction word.
- o_stall  out  1  freezes the core pipeline while high.
- o_cpu_rst  out  1  active-high core soft reset.
- o_reg_sel  out  $clog2(NUM_REGISTERS)  register file debug read select.
- i_reg_data  in  SIZE  register file debug read data, one-cycle latency.
- i_pc  in  SIZE  current PC.
- i_halt  in  1  core has executed a halt instruction.

Behaviour:
- Reset values: o_stall=1; every other output 0; state IDLE.
- Outputs are registered.
- Multi-byte fields are little-endian, SIZE/8 bytes each.
- Replies: ACK=0xA5, ERR=0xEE.
- IDLE decodes the command byte on i_rx_valid:
  - 'L' 0x4C -> LOAD_CNT.
  - 'R' 0x52 -> RUN.
  - 'S' 0x53 -> STEP.
  - 'D' 0x44 -> DUMP.
  - 'X' 0x58 -> CPURST.
  - Any other byte -> send ERR.
- LOAD_CNT: the next byte is N.
  - N==0 or N>MAX_INSTRUCTION -> ERR, back to IDLE.
  - Otherwise the address counter is cleared -> LOAD_DATA.
- LOAD_DATA:
  - Assemble one word from SIZE/8 bytes.
  - On the final byte, the next cycle pulses o_imem_wr_en for one cycle with o_imem_addr/o_imem_wr_data; the address then increments.
  - After the N-th word, send ACK.
  - o_stall stays 1 throughout.
- RUN:
  - o_stall=0 from the cycle after entry.
  - When i_halt=1 or any rx byte arrives (the byte is discarded), o_stall=1 at the next edge, then send ACK.
  - If i_halt is already 1 on entry, o_stall never drops; send ACK.
- STEP: o_stall=0 for exactly one cycle, then 1; send ACK.
- CPURST: o_cpu_rst=1 for CPU_RST_CYCLES cycles with o_stall=1; send ACK.
- DUMP:
  - Send the SIZE/8 bytes of i_pc, captured on entry.
  - Then for r=0..NUM_REGISTERS-1: drive o_reg_sel=r, wait one cycle, capture i_reg_data, send its bytes.
  - No ACK; the total is (NUM_REGISTERS+1)*SIZE/8 bytes.
- TX handshake:
  - o_tx_start is a single-cycle pulse with o_tx_data held stable.
  - The next byte is not started until i_tx_done is seen.
  - An i_tx_done arriving in the same cycle as a new request is honoured first.
- RX bytes arriving in any state other than IDLE, LOAD_CNT, LOAD_DATA or RUN are dropped.
- Reset asserted mid-operation aborts immediately: load is partial, memory contents are kept, and outputs return to reset values.

Optional Feature:
- Macro: MIPS_DEBUG_CTRL_TIMEOUT_EN.
- With the macro: in LOAD_CNT/LOAD_DATA, a counter cleared on every i_rx_valid reaches TIMEOUT_CYCLES -> send ERR, return to IDLE; words already written remain.
- Without the macro: no counter exists and the controller waits indefinitely for bytes.

Test Plan:
- Reset -> o_stall=1, o_tx_start=0, o_imem_wr_en=0, o_cpu_rst=0.
- Send 0x4C, 0x02, bytes 78 56 34 12 EF BE AD DE -> writes addr0=0x12345678, addr1=0xDEADBEEF, one wr_en pulse each, then tx 0xA5.
- Send 0x4C, 0x00 -> tx 0xEE, no writes.
- Send 0x4C, 0x41 (65) -> tx 0xEE, no writes.
- Send 0x53 -> o_stall low exactly 1 cycle, then tx 0xA5.
- Send 0x52, raise i_halt 20 cycles later -> o_stall low ≥20 cycles, high the cycle after i_halt, tx 0xA5.
- Preload regs r=0..31 to value r*3, i_pc=0x40, send 0x44 -> 132 bytes: 40 00 00 00, then 00 00 00 00, 03 00 00 00, ... ending 5D 00 00 00.
- Timeout (macro defined, TIMEOUT_CYCLES=100): send 0x4C, 0x01, 2 bytes, then idle 100 cycles -> tx 0xEE, IDLE.
- Timeout (macro undefined): same stimulus -> no tx.

Source files
------------

// File: rtl/mips_debug_ctrl.sv
// mips_debug_ctrl: UART byte-level debug controller for the MIPS core.
// Optional inter-byte load timeout enabled by MIPS_DEBUG_CTRL_TIMEOUT_EN.
module mips_debug_ctrl #(
  parameter int SIZE            = 32,
  parameter int NUM_REGISTERS   = 32,
  parameter int MAX_INSTRUCTION = 64,
  parameter int ADDR_WIDTH      = $clog2(MAX_INSTRUCTION),
  parameter int CPU_RST_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [7:0]                       i_rx_data,
  input  logic                             i_rx_valid,
  output logic [7:0]                       o_tx_data,
  output logic                             o_tx_start,
  input  logic                             i_tx_done,
  output logic                             o_imem_wr_en,
  output logic [ADDR_WIDTH-1:0]            o_imem_addr,
  output logic [SIZE-1:0]                  o_imem_wr_data,
  output logic                             o_stall,
  output logic                             o_cpu_rst,
  output logic [$clog2(NUM_REGISTERS)-1:0] o_reg_sel,
  input  logic [SIZE-1:0]                  i_reg_data,
  input  logic [SIZE-1:0]                  i_pc,
  input  logic                             i_halt
);

  localparam int NB  = SIZE / 8;
  localparam int BW  = $clog2(NB + 1);
  localparam int RSW = $clog2(NUM_REGISTERS);
  localparam int RIW = RSW + 1;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > CPU_RST_CYCLES) ?
                           TIMEOUT_CYCLES : CPU_RST_CYCLES;
  localparam int CW  = $clog2(CNT_MAX + 1);

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] ERR = 8'hEE;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_CNT,
    S_LOAD_DATA,
    S_RUN,
    S_STEP,
    S_STEP_END,
    S_CPURST,
    S_DUMP_TX,
    S_DUMP_SEL,
    S_DUMP_CAP,
    S_REPLY,
    S_TX_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [SIZE-1:0]       word_q, word_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            n_q, n_d;
  logic [RIW-1:0]        ridx_q, ridx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [7:0]            reply_q, reply_d;
  logic                  busy_q, busy_d;

  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [SIZE-1:0]       wr_data_q, wr_data_d;
  logic                  stall_q, stall_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic [RSW-1:0]        reg_sel_q, reg_sel_d;

  logic                  tx_free;
  logic [SIZE-1:0]       word_in;

  // A pending tx_done frees the transmitter in the same cycle.
  assign tx_free = !busy_q || i_tx_done;
  assign word_in = (word_q >> 8) | (SIZE'(i_rx_data) << (SIZE - 8));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    bcnt_d      = bcnt_q;
    addr_d      = addr_q;
    n_d         = n_q;
    ridx_d      = ridx_q;
    cnt_d       = cnt_q;
    reply_d     = reply_q;
    busy_d      = busy_q && !i_tx_done;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    wr_en_d     = 1'b0;
    imem_addr_d = imem_addr_q;
    wr_data_d   = wr_data_q;
    stall_d     = stall_q;
    cpu_rst_d   = cpu_rst_q;
    reg_sel_d   = reg_sel_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_rx_valid) begin
          unique case (i_rx_data)
            8'h4C: begin
              cnt_d   = '0;
              state_d = S_LOAD_CNT;
            end
            8'h52: state_d = S_RUN;
            8'h53: state_d = S_STEP;
            8'h44: begin
              word_d  = i_pc;
              bcnt_d  = '0;
              ridx_d  = '0;
              state_d = S_DUMP_TX;
            end
            8'h58: begin
              cnt_d   = '0;
              state_d = S_CPURST;
            end
            default: begin
              reply_d = ERR;
              state_d = S_REPLY;
            end
          endcase
        end
      end

      S_LOAD_CNT: begin
        if (i_rx_valid) begin
          if (i_rx_data == 8'd0 ||
              32'(i_rx_data) > 32'(MAX_INSTRUCTION)) begin
            reply_d = ERR;
            state_d = S_REPLY;
          end else begin
            n_d     = i_rx_data;
            addr_d  = '0;
            bcnt_d  = '0;
            state_d = S_LOAD_DATA;
          end
        end
`ifdef MIPS_DEBUG_CTRL_TIMEOUT_EN
        cnt_d = i_rx_valid ? '0 : cnt_q + 1'b1;
        if (!i_rx_valid && cnt_q + 1'b1 == CW'(TIMEOUT_CYCLES)) begin
          reply_d = ERR;
          state_d = S_REPLY;
        end
`endif
      end

      S_LOAD_DATA: begin
        if (i_rx_valid) begin
          word_d = word_in;
          if (bcnt_q == BW'(NB - 1)) begin
            wr_en_d     = 1'b1;
            imem_addr_d = addr_q;
            wr_data_d   = word_in;
            addr_d      = addr_q + 1'b1;
            bcnt_d      = '0;
            if (32'(addr_q) + 32'd1 == 32'(n_q)) begin
              reply_d = ACK;
              state_d = S_REPLY;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
`ifdef MIPS_DEBUG_CTRL_TIMEOUT_EN
        cnt_d = i_rx_valid ? '0 : cnt_q + 1'b1;
        if (!i_rx_valid && cnt_q + 1'b1 == CW'(TIMEOUT_CYCLES)) begin
          reply_d = ERR;
          state_d = S_REPLY;
        end
`endif
      end

      S_RUN: begin
        if (i_halt || i_rx_valid) begin
          stall_d = 1'b1;
          reply_d = ACK;
          state_d = S_REPLY;
        end else begin
          stall_d = 1'b0;
        end
      end

      S_STEP: begin
        stall_d = 1'b0;
        state_d = S_STEP_END;
      end

      S_STEP_END: begin
        stall_d = 1'b1;
        reply_d = ACK;
        state_d = S_REPLY;
      end

      S_CPURST: begin
        if (cnt_q == CW'(CPU_RST_CYCLES)) begin
          cpu_rst_d = 1'b0;
          reply_d   = ACK;
          state_d   = S_REPLY;
        end else begin
          cpu_rst_d = 1'b1;
          cnt_d     = cnt_q + 1'b1;
        end
      end

      S_DUMP_TX: begin
        if (bcnt_q == BW'(NB)) begin
          if (ridx_q == RIW'(NUM_REGISTERS)) begin
            state_d = S_TX_WAIT;
          end else begin
            reg_sel_d = ridx_q[RSW-1:0];
            state_d   = S_DUMP_SEL;
          end
        end else if (tx_free) begin
          tx_start_d = 1'b1;
          tx_data_d  = word_q[7:0];
          busy_d     = 1'b1;
          word_d     = word_q >> 8;
          bcnt_d     = bcnt_q + 1'b1;
        end
      end

      S_DUMP_SEL: state_d = S_DUMP_CAP;

      S_DUMP_CAP: begin
        word_d  = i_reg_data;
        bcnt_d  = '0;
        ridx_d  = ridx_q + 1'b1;
        state_d = S_DUMP_TX;
      end

      S_REPLY: begin
        if (tx_free) begin
          tx_start_d = 1'b1;
          tx_data_d  = reply_q;
          busy_d     = 1'b1;
          state_d    = S_TX_WAIT;
        end
      end

      S_TX_WAIT: begin
        if (!busy_q || i_tx_done) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      word_q      <= '0;
      bcnt_q      <= '0;
      addr_q      <= '0;
      n_q         <= '0;
      ridx_q      <= '0;
      cnt_q       <= '0;
      reply_q     <= '0;
      busy_q      <= 1'b0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      imem_addr_q <= '0;
      wr_data_q   <= '0;
      stall_q     <= 1'b1;
      cpu_rst_q   <= 1'b0;
      reg_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      bcnt_q      <= bcnt_d;
      addr_q      <= addr_d;
      n_q         <= n_d;
      ridx_q      <= ridx_d;
      cnt_q       <= cnt_d;
      reply_q     <= reply_d;
      busy_q      <= busy_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      wr_en_q     <= wr_en_d;
      imem_addr_q <= imem_addr_d;
      wr_data_q   <= wr_data_d;
      stall_q     <= stall_d;
      cpu_rst_q   <= cpu_rst_d;
      reg_sel_q   <= reg_sel_d;
    end
  end

  assign o_tx_data      = tx_data_q;
  assign o_tx_start     = tx_start_q;
  assign o_imem_wr_en   = wr_en_q;
  assign o_imem_addr    = imem_addr_q;
  assign o_imem_wr_data = wr_data_q;
  assign o_stall        = stall_q;
  assign o_cpu_rst      = cpu_rst_q;
  assign o_reg_sel      = reg_sel_q;

endmodule
